// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
//   Sequencing controller for the EX-stage ALU. Takes one operation at a time
//   over a valid/ready request channel and returns the result over a
//   valid/ready response channel. Logic ops, add/sub and addi finish in a single
//   cycle. MUL is an iterative shift-add that retires MUL_STEP multiplier bits
//   per cycle. stall_o freezes the upstream pipeline registers while a request
//   is waiting but cannot be taken.
//
// Handshake rules (both channels):
//   A transfer happens on a rising clk_i edge where valid and ready are both 1.
//   The request side captures ctrl_i/data1_i/data2_i at that edge and ignores
//   them afterwards. The response side holds data_o/zero_o stable while
//   rsp_valid_o is high and rsp_ready_i is low.
//
// Ports
//   clk_i        in   1      clock, rising edge
//   rst_i        in   1      asynchronous reset, active-low
//   req_valid_i  in   1      operation request valid
//   req_ready_o  out  1      request can be accepted this cycle
//   ctrl_i       in   4      ALU control code (bit 3 ignored)
//   data1_i      in   WIDTH  operand 1
//   data2_i      in   WIDTH  operand 2
//   rsp_valid_o  out  1      result valid
//   rsp_ready_i  in   1      consumer takes result this cycle
//   data_o       out  WIDTH  result
//   zero_o       out  1      data_o == 0
//   busy_o       out  1      multiply in progress
//   stall_o      out  1      request waiting and refused
//   state_o      out  2      FSM state for debug (0 IDLE, 1 MUL, 2 RESP)
// -----------------------------------------------------------------------------
module alu_seq_ctrl #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1   // 1, 2 or 4; must divide WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int NSTEPS = WIDTH / MUL_STEP;
  localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEPS - 1);

  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_ADD  = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_step;
  logic             accept;
  logic             unused_ctrl3;

  assign unused_ctrl3 = ctrl_i[3];

  // Ready while idle, or in RESP when the current result leaves this very
  // cycle (combinational from rsp_ready_i so back-to-back ops have no bubble).
  assign req_ready_o = (state_q == IDLE) | ((state_q == RESP) & rsp_ready_i);
  assign accept      = req_valid_i & req_ready_o;
  assign stall_o     = req_valid_i & ~req_ready_o;

  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q == MUL);
  assign data_o      = data_q;
  assign zero_o      = zero_q;
  assign state_o     = state_q;

  // Single-cycle result; MUL and unused codes produce 0 here.
  always_comb begin
    alu_res = '0;
    case (ctrl_i[2:0])
      OP_ADDI: alu_res = data1_i + (data2_i >> 20);
      OP_SUB:  alu_res = data1_i - data2_i;
      OP_OR:   alu_res = data1_i | data2_i;
      OP_AND:  alu_res = data1_i & data2_i;
      OP_ADD:  alu_res = data1_i + data2_i;
      default: alu_res = '0;
    endcase
  end

  // One shift-add iteration: add mcand shifted by each set bit of the low
  // MUL_STEP multiplier bits. Bits shifted past WIDTH cannot affect the low
  // WIDTH bits of the product, so they are simply dropped.
  always_comb begin
    acc_step = acc_q;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (mplier_q[k]) begin
        acc_step = acc_step + (mcand_q << k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    zero_d   = zero_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (ctrl_i[2:0] == OP_MUL) begin
            state_d  = MUL;
            acc_d    = '0;
            mcand_d  = data1_i;
            mplier_d = data2_i;
            cnt_d    = CNT_LAST;
          end else begin
            state_d = RESP;
            data_d  = alu_res;
            zero_d  = (alu_res == '0);
          end
        end else if ((state_q == RESP) && rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << MUL_STEP;
        mplier_d = mplier_q >> MUL_STEP;
        if (cnt_q == '0) begin
          data_d  = acc_step;
          zero_d  = (acc_step == '0);
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      data_q   <= '0;
      zero_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
//   Directed bench for alu_seq_ctrl at default parameters. Inputs change and
//   outputs are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  ctrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] data_o;
  logic        zero_o;
  logic        busy_o;
  logic        stall_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;
  int n;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_seq_ctrl #(.WIDTH(32), .MUL_STEP(1)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .ctrl_i      (ctrl_i),
    .data1_i     (data1_i),
    .data2_i     (data2_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .data_o      (data_o),
    .zero_o      (zero_o),
    .busy_o      (busy_o),
    .stall_o     (stall_o),
    .state_o     (state_o)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_valid_i = 1'b1;
    ctrl_i      = c;
    data1_i     = a;
    data2_i     = b;
    #1;
  endtask

  // Single-cycle op from IDLE with rsp_ready_i=1: result one cycle after accept,
  // then back to IDLE with data_o kept.
  task automatic single(input string tag, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    set_req(c, a, b);
    check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    data1_i     = 32'hDEAD_BEEF;
    data2_i     = 32'h1234_5678;
    #1;
    check({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
    check({tag, "_data"},  data_o, exp);
    check({tag, "_zero"},  32'(zero_o), 32'(exp == 32'd0));
    tick();
    check({tag, "_valid_fall"}, 32'(rsp_valid_o), 32'd0);
    check({tag, "_data_kept"},  data_o, exp);
  endtask

  // Counts cycles in MUL until rsp_valid_o, checking busy_o each cycle.
  task automatic mul_wait(input string tag, output int cyc);
    cyc = 0;
    while (rsp_valid_o !== 1'b1 && cyc < 100) begin
      check({tag, "_busy"}, 32'(busy_o), 32'd1);
      tick();
      cyc++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_i       = 1'b0;
    req_valid_i = 1'b0;
    ctrl_i      = 4'd0;
    data1_i     = '0;
    data2_i     = '0;
    rsp_ready_i = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_data",  data_o, 32'd0);
    check("rst_zero",  32'(zero_o), 32'd0);
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    rst_i       = 1'b1;
    rsp_ready_i = 1'b1;
    #1;

    // 1) add with latency 1
    set_req(4'b0111, 32'd5, 32'd7);
    check("add_pre_valid", 32'(rsp_valid_o), 32'd0);
    req_valid_i = 1'b0;
    #1;
    single("add", 4'b0111, 32'd5, 32'd7, 32'd12);
    check("add_idle", 32'(state_o), 32'd0);

    // 2) sub / addi / ctrl bit 3 ignored
    single("sub_zero", 4'b0011, 32'd9, 32'd9, 32'd0);
    single("sub_wrap", 4'b0011, 32'd0, 32'd1, 32'hFFFF_FFFF);
    single("addi",     4'b0001, 32'd1, 32'h0030_0000, 32'd4);
    single("add_b3",   4'b1111, 32'd3, 32'd4, 32'd7);

    // 3) mul with a second request held while busy
    set_req(4'b0100, 32'h0001_0003, 32'h0000_0005);
    tick();
    set_req(4'b0111, 32'd10, 32'd20);
    check("mul_stall", 32'(stall_o), 32'd1);
    check("mul_not_ready", 32'(req_ready_o), 32'd0);
    check("mul_no_valid", 32'(rsp_valid_o), 32'd0);
    mul_wait("mul1", n);
    check("mul1_latency", 32'(n), 32'd32);
    check("mul1_data", data_o, 32'h0005_000F);
    check("mul1_zero", 32'(zero_o), 32'd0);
    check("mul1_held_ready", 32'(req_ready_o), 32'd1);
    check("mul1_stall_low", 32'(stall_o), 32'd0);
    tick();
    req_valid_i = 1'b0;
    #1;
    check("held_add_valid", 32'(rsp_valid_o), 32'd1);
    check("held_add_data", data_o, 32'd30);
    tick();
    check("held_add_fall", 32'(rsp_valid_o), 32'd0);

    set_req(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    req_valid_i = 1'b0;
    #1;
    mul_wait("mul2", n);
    check("mul2_latency", 32'(n), 32'd32);
    check("mul2_data", data_o, 32'd1);
    tick();
    check("mul2_fall", 32'(rsp_valid_o), 32'd0);

    // 4) back-to-back: or, and, then mul (rsp_valid falls on the mul accept)
    set_req(4'b0101, 32'h0000_00F0, 32'h0000_000F);
    tick();
    check("or_valid", 32'(rsp_valid_o), 32'd1);
    check("or_data", data_o, 32'h0000_00FF);
    set_req(4'b0110, 32'h0000_00FF, 32'h0000_003C);
    check("and_ready", 32'(req_ready_o), 32'd1);
    tick();
    check("and_valid", 32'(rsp_valid_o), 32'd1);
    check("and_data", data_o, 32'h0000_003C);
    set_req(4'b0100, 32'd6, 32'd7);
    tick();
    req_valid_i = 1'b0;
    #1;
    check("b2b_mul_valid_low", 32'(rsp_valid_o), 32'd0);
    check("b2b_mul_busy", 32'(busy_o), 32'd1);
    mul_wait("mul3", n);
    check("mul3_latency", 32'(n), 32'd32);
    check("mul3_data", data_o, 32'd42);
    tick();

    // 5) backpressure
    rsp_ready_i = 1'b0;
    set_req(4'b0111, 32'd1, 32'd1);
    tick();
    set_req(4'b0011, 32'd9, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(rsp_valid_o), 32'd1);
      check("bp_data", data_o, 32'd2);
      check("bp_not_ready", 32'(req_ready_o), 32'd0);
      check("bp_stall", 32'(stall_o), 32'd1);
      tick();
    end
    check("bp_still_held", data_o, 32'd2);
    rsp_ready_i = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready_o), 32'd1);
    check("bp_release_stall", 32'(stall_o), 32'd0);
    tick();
    req_valid_i = 1'b0;
    #1;
    check("bp_next_valid", 32'(rsp_valid_o), 32'd1);
    check("bp_next_data", data_o, 32'd5);
    tick();
    check("bp_idle", 32'(state_o), 32'd0);

    // 6) reset mid-mul
    set_req(4'b0100, 32'd123, 32'd456);
    tick();
    req_valid_i = 1'b0;
    repeat (10) tick();
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("mrst_valid", 32'(rsp_valid_o), 32'd0);
    check("mrst_data",  data_o, 32'd0);
    check("mrst_zero",  32'(zero_o), 32'd0);
    check("mrst_busy",  32'(busy_o), 32'd0);
    check("mrst_state", 32'(state_o), 32'd0);
    tick();
    rst_i = 1'b1;
    #1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) n++;
      tick();
    end
    check("mrst_no_result", 32'(n), 32'd0);
    single("post_rst_add", 4'b0111, 32'd2, 32'd3, 32'd5);
    single("code000", 4'b0000, 32'd7, 32'd9, 32'd0);
    single("code010", 4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
